// File: rtl/alu_issue_if.sv
// Issue-stage bus: decode request, operand bypasses, flush, ALU-side outputs and the
// issue counter. master = decode/hazard side, slave = the issue stage.
interface alu_issue_if #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned CNT_W     = 32
);
   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0]           in_aluc;
   logic [REG_IDX_W-1:0] in_rs_idx;
   logic [DATA_W-1:0]    in_rs_val;
   logic [REG_IDX_W-1:0] in_rt_idx;
   logic [DATA_W-1:0]    in_rt_val;
   logic [15:0]          in_imm;
   logic [4:0]           in_shamt;
   logic                 in_b_imm;
   logic                 in_imm_sext;
   logic                 in_a_shamt;
   logic [REG_IDX_W-1:0] in_rd_idx;
   logic                 in_wr_en;
   logic                 fwd1_en;
   logic [REG_IDX_W-1:0] fwd1_idx;
   logic [DATA_W-1:0]    fwd1_data;
   logic                 fwd2_en;
   logic [REG_IDX_W-1:0] fwd2_idx;
   logic [DATA_W-1:0]    fwd2_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [3:0]           Aluc;
   logic [DATA_W-1:0]    a;
   logic [DATA_W-1:0]    b;
   logic [REG_IDX_W-1:0] out_rd_idx;
   logic                 out_wr_en;
   logic [CNT_W-1:0]     issue_cnt;

   modport master (
      output flush, in_valid, in_aluc, in_rs_idx, in_rs_val, in_rt_idx, in_rt_val,
             in_imm, in_shamt, in_b_imm, in_imm_sext, in_a_shamt, in_rd_idx, in_wr_en,
             fwd1_en, fwd1_idx, fwd1_data, fwd2_en, fwd2_idx, fwd2_data, out_ready,
      input  in_ready, out_valid, Aluc, a, b, out_rd_idx, out_wr_en, issue_cnt
   );

   modport slave (
      input  flush, in_valid, in_aluc, in_rs_idx, in_rs_val, in_rt_idx, in_rt_val,
             in_imm, in_shamt, in_b_imm, in_imm_sext, in_a_shamt, in_rd_idx, in_wr_en,
             fwd1_en, fwd1_idx, fwd1_data, fwd2_en, fwd2_idx, fwd2_data, out_ready,
      output in_ready, out_valid, Aluc, a, b, out_rd_idx, out_wr_en, issue_cnt
   );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-entry pipeline register in front of the ALU: resolves operands (shamt/imm
// select, two-level forwarding, $0 rule) and registers Aluc/a/b with a valid/ready
// handshake, stall and flush. Counts ops issued (wrapping).
module alu_issue_stage #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_IDX_W = 5,
   parameter int unsigned CNT_W     = 32
) (
   input logic         clk,
   input logic         rst_n,
   alu_issue_if.slave  bus
);
   logic                 valid_q, valid_d;
   logic [3:0]           aluc_q;
   logic [DATA_W-1:0]    a_q, a_d;
   logic [DATA_W-1:0]    b_q, b_d;
   logic [REG_IDX_W-1:0] rd_q;
   logic                 wr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 in_ready;
   logic                 accept;
   logic [DATA_W-1:0]    rs_op, rt_op, imm_ext;

   // Ready is independent of in_valid so decode never sees a combinational loop.
   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready && !bus.flush;

   // Operand resolution: $0 is never forwarded; newer bypass (fwd1) wins over older.
   always_comb begin
      rs_op = bus.in_rs_val;
      if (bus.in_rs_idx == '0) begin
         rs_op = '0;
      end else if (bus.fwd1_en && (bus.fwd1_idx == bus.in_rs_idx)) begin
         rs_op = bus.fwd1_data;
      end else if (bus.fwd2_en && (bus.fwd2_idx == bus.in_rs_idx)) begin
         rs_op = bus.fwd2_data;
      end

      rt_op = bus.in_rt_val;
      if (bus.in_rt_idx == '0) begin
         rt_op = '0;
      end else if (bus.fwd1_en && (bus.fwd1_idx == bus.in_rt_idx)) begin
         rt_op = bus.fwd1_data;
      end else if (bus.fwd2_en && (bus.fwd2_idx == bus.in_rt_idx)) begin
         rt_op = bus.fwd2_data;
      end

      imm_ext = bus.in_imm_sext ? {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm}
                                : {{(DATA_W-16){1'b0}}, bus.in_imm};
      a_d     = bus.in_a_shamt ? {{(DATA_W-5){1'b0}}, bus.in_shamt} : rs_op;
      b_d     = bus.in_b_imm ? imm_ext : rt_op;
   end

   // Valid next state: flush dominates, then accept, then a consumed op drains.
   always_comb begin
      valid_d = valid_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Handshake state and issue counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Payload registers load only on accept, so a stalled op stays bit-stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluc_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         rd_q   <= '0;
         wr_q   <= 1'b0;
      end else if (accept) begin
         aluc_q <= bus.in_aluc;
         a_q    <= a_d;
         b_q    <= b_d;
         rd_q   <= bus.in_rd_idx;
         wr_q   <= bus.in_wr_en && (bus.in_rd_idx != '0);
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid_q;
   assign bus.Aluc       = aluc_q;
   assign bus.a          = a_q;
   assign bus.b          = b_q;
   assign bus.out_rd_idx = rd_q;
   assign bus.out_wr_en  = wr_q;
   assign bus.issue_cnt  = cnt_q;
endmodule
